// File: rtl/bch_frame_ctrl.sv
// Codeword framing controller: tracks symbol position, emits start/last/abort
// tags, flags framing errors and re-times the tags through a pLatency-deep pipe.
module bch_frame_ctrl #(
  parameter int pCodeLen  = 15,
  parameter int pCntWidth = 4,
  parameter int pLatency  = 4
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic                 i_valid,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic [pCntWidth-1:0] o_sym_idx,
  output logic                 o_cw_valid,
  output logic                 o_cw_start,
  output logic                 o_cw_last,
  output logic                 o_cw_abort,
  output logic                 o_err,
  output logic                 o_dly_valid,
  output logic                 o_dly_start,
  output logic                 o_dly_last,
  output logic                 o_dly_abort,
  output logic [15:0]          o_blk_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Compared before incrementing, so pCodeLen = 2**pCntWidth never overflows.
  localparam logic [pCntWidth-1:0] LAST_IDX = pCntWidth'(pCodeLen - 1);
  localparam logic [pCntWidth-1:0] ONE_IDX  = pCntWidth'(1);

  state_t                        state_q, state_d;
  logic [pCntWidth-1:0]          cnt_q, cnt_d;
  logic [pCntWidth-1:0]          idx_q, idx_d;
  logic                          cw_valid_q, cw_valid_d;
  logic                          cw_start_q, cw_start_d;
  logic                          cw_last_q, cw_last_d;
  logic                          cw_abort_q, cw_abort_d;
  logic                          err_q, err_d;
  logic [15:0]                   blk_q, blk_d;
  logic [pLatency-1:0][3:0]      pipe_q, pipe_d;

  // Next-state, symbol index and tag generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cw_valid_d = 1'b0;
    cw_start_d = 1'b0;
    cw_last_d  = 1'b0;
    cw_abort_d = 1'b0;
    err_d      = 1'b0;
    blk_d      = blk_q;
    case (state_q)
      IDLE: begin
        if (i_valid && i_start) begin
          state_d    = RUN;
          cnt_d      = ONE_IDX;
          idx_d      = '0;
          cw_valid_d = 1'b1;
          cw_start_d = 1'b1;
        end else if (i_valid) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (i_valid && i_start) begin
          // Restart wins over a pending last symbol; the old codeword is dropped.
          cnt_d      = ONE_IDX;
          idx_d      = '0;
          cw_valid_d = 1'b1;
          cw_start_d = 1'b1;
          cw_abort_d = 1'b1;
          err_d      = 1'b1;
        end else if (i_valid) begin
          idx_d      = cnt_q;
          cw_valid_d = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cw_last_d = 1'b1;
            blk_d     = blk_q + 16'd1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + ONE_IDX;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Tag delay pipe: stage 0 takes the registered tag tuple.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {cw_valid_q, cw_start_q, cw_last_q, cw_abort_q};
    for (int i = 1; i < pLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State, tag and counter registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      cw_valid_q <= 1'b0;
      cw_start_q <= 1'b0;
      cw_last_q  <= 1'b0;
      cw_abort_q <= 1'b0;
      err_q      <= 1'b0;
      blk_q      <= 16'd0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cw_valid_q <= cw_valid_d;
      cw_start_q <= cw_start_d;
      cw_last_q  <= cw_last_d;
      cw_abort_q <= cw_abort_d;
      err_q      <= err_d;
      blk_q      <= blk_d;
      pipe_q     <= pipe_d;
    end
  end

  assign o_busy      = (state_q == RUN);
  assign o_sym_idx   = idx_q;
  assign o_cw_valid  = cw_valid_q;
  assign o_cw_start  = cw_start_q;
  assign o_cw_last   = cw_last_q;
  assign o_cw_abort  = cw_abort_q;
  assign o_err       = err_q;
  assign o_blk_cnt   = blk_q;
  assign o_dly_valid = pipe_q[pLatency-1][3];
  assign o_dly_start = pipe_q[pLatency-1][2];
  assign o_dly_last  = pipe_q[pLatency-1][1];
  assign o_dly_abort = pipe_q[pLatency-1][0];

endmodule

// File: tb/tb_bch_frame_ctrl.sv
// Directed bench for bch_frame_ctrl (pCodeLen=15, pLatency=4): every output is
// compared each cycle against hand-derived expectations.
module tb_bch_frame_ctrl;

  logic        clk;
  logic        rst_x;
  logic        i_valid;
  logic        i_start;
  logic        o_busy;
  logic [3:0]  o_sym_idx;
  logic        o_cw_valid, o_cw_start, o_cw_last, o_cw_abort, o_err;
  logic        o_dly_valid, o_dly_start, o_dly_last, o_dly_abort;
  logic [15:0] o_blk_cnt;

  int          vectors = 0;
  int          fails   = 0;
  logic        exp_busy;
  logic [15:0] exp_blk;
  logic [3:0]  hist [4];

  bch_frame_ctrl #(.pCodeLen(15), .pCntWidth(4), .pLatency(4)) dut (
    .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .i_start(i_start),
    .o_busy(o_busy), .o_sym_idx(o_sym_idx), .o_cw_valid(o_cw_valid),
    .o_cw_start(o_cw_start), .o_cw_last(o_cw_last), .o_cw_abort(o_cw_abort),
    .o_err(o_err), .o_dly_valid(o_dly_valid), .o_dly_start(o_dly_start),
    .o_dly_last(o_dly_last), .o_dly_abort(o_dly_abort), .o_blk_cnt(o_blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: apply inputs, sample 1ns after the edge, compare every output.
  // The delayed tags are expected to equal the tags expected four cycles ago.
  task automatic cyc(input string tag, input logic v, input logic s,
                     input logic ev, input logic es, input logic el,
                     input logic ea, input logic eerr, input logic [3:0] eidx);
    logic [29:0] obs, exp;
    i_valid = v;
    i_start = s;
    @(posedge clk);
    #1;
    obs = {o_busy, o_sym_idx, o_cw_valid, o_cw_start, o_cw_last, o_cw_abort, o_err,
           o_dly_valid, o_dly_start, o_dly_last, o_dly_abort, o_blk_cnt};
    exp = {exp_busy, eidx, ev, es, el, ea, eerr, hist[3], exp_blk};
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {ev, es, el, ea};
  endtask

  // Contiguous symbols lo..hi of a codeword; optional start tag on the first.
  task automatic cw_syms(input string tag, input int lo, input int hi, input logic st);
    for (int i = lo; i <= hi; i++) begin
      logic s;
      s = st && (i == lo);
      if (i == 14) begin
        exp_busy = 1'b0;
        exp_blk  = exp_blk + 16'd1;
      end else begin
        exp_busy = 1'b1;
      end
      cyc(tag, 1'b1, s, 1'b1, s, (i == 14), 1'b0, 1'b0, 4'(i));
    end
  endtask

  task automatic idles(input string tag, input int n, input logic [3:0] eidx);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eidx);
    end
  endtask

  task automatic do_reset(input string tag);
    i_valid  = 1'b0;
    i_start  = 1'b0;
    rst_x    = 1'b0;
    exp_busy = 1'b0;
    exp_blk  = 16'd0;
    for (int i = 0; i < 4; i++) hist[i] = 4'b0000;
    idles(tag, 2, 4'd0);
    rst_x = 1'b1;
  endtask

  initial begin
    rst_x   = 1'b0;
    i_valid = 1'b0;
    i_start = 1'b0;
    do_reset("reset");
    idles("post_reset", 1, 4'd0);

    // Single codeword, then let the delay pipe drain.
    cw_syms("cw1", 0, 14, 1'b1);
    idles("cw1_drain", 5, 4'd14);

    // Back-to-back codewords with zero bubble.
    cw_syms("b2b_a", 0, 14, 1'b1);
    cw_syms("b2b_b", 0, 14, 1'b1);
    idles("b2b_drain", 5, 4'd14);

    // Three-cycle gap after idx 5: index held, busy stays high.
    cw_syms("gap_a", 0, 5, 1'b1);
    exp_busy = 1'b1;
    idles("gap_hold", 3, 4'd5);
    cw_syms("gap_b", 6, 14, 1'b0);
    idles("gap_drain", 5, 4'd14);

    // Restart after 7 symbols: abort, err and start together on idx 0.
    cw_syms("abort_a", 0, 6, 1'b1);
    exp_busy = 1'b1;
    cyc("abort_pulse", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    cw_syms("abort_b", 1, 14, 1'b0);
    idles("abort_drain", 5, 4'd14);

    // Valid without start while idle: one error pulse, nothing else.
    cyc("idle_err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd14);
    idles("idle_err_after", 2, 4'd14);

    // Reset in the middle of a codeword, then a fresh one.
    cw_syms("rst_a", 0, 9, 1'b1);
    #2;
    do_reset("mid_reset");
    cw_syms("rst_b", 0, 14, 1'b1);
    idles("rst_drain", 5, 4'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/bch_frame_ctrl.md
Name: bch_frame_ctrl

Overview:
Codeword framing controller for the BCH decode datapath. Tracks symbol position within each pCodeLen-symbol codeword from the input valid/start strobes. Generates per-codeword start/last/abort tags, then re-times them through a pLatency-cycle control delay so the tags line up with data leaving the fixed-latency datapath (syndrome and delay-buffer stage). Also flags framing protocol errors and counts completed codewords.

Parameters:
pCodeLen, 15, symbols per codeword; legal range is 2 to 2**pCntWidth.
pCntWidth, 4, width of the symbol index counter.
pLatency, 4, datapath latency in cycles that the tags must match; must be at least 1.

Ports:
clk  input  1  clock
rst_x  input  1  asynchronous reset, active low
i_valid  input  1  input symbol valid this cycle
i_start  input  1  first symbol of a codeword; qualified by i_valid
o_busy  output  1  codeword in progress (FSM in RUN)
o_sym_idx  output  pCntWidth  index of the symbol accepted in the previous cycle, from 0 to pCodeLen-1
o_cw_valid  output  1  registered copy of the accepted-symbol strobe
o_cw_start  output  1  accepted symbol was index 0
o_cw_last  output  1  accepted symbol was index pCodeLen-1
o_cw_abort  output  1  previous codeword was aborted (one-cycle pulse)
o_err  output  1  framing error (one-cycle pulse)
o_dly_valid  output  1  o_cw_valid delayed by pLatency cycles
o_dly_start  output  1  o_cw_start delayed by pLatency cycles
o_dly_last  output  1  o_cw_last delayed by pLatency cycles
o_dly_abort  output  1  o_cw_abort delayed by pLatency cycles
o_blk_cnt  output  16  count of completed codewords; wraps at 2**16

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0, delay pipe cleared. Reset asserted mid-codeword discards the partial codeword, with no abort or error reported.
- FSM states:
  - IDLE, entered at reset or after a last symbol.
  - RUN, a codeword is partially received.
- Accepted symbol, per state:
  - IDLE: i_valid & i_start.
  - RUN: any i_valid.
- Transitions and actions:
  - IDLE, i_valid & i_start: go to RUN, idx=0, start tag set. Counter now holds 1.
  - IDLE, i_valid & !i_start: symbol ignored, o_err pulses, stay IDLE.
  - RUN, i_valid & !i_start: idx = current count; counter increments.
  - RUN, i_valid & count = pCodeLen-1: last tag set, o_blk_cnt increments, go to IDLE, counter reset to 0.
  - RUN, i_valid & i_start: abort plus restart. o_cw_abort and o_err pulse; the new symbol is idx 0 with the start tag; counter becomes 1; stay RUN; o_blk_cnt unchanged.
  - i_valid low: no action, counter held. Gaps of any length are allowed.
- Back-to-back: i_start with i_valid in the cycle right after a last symbol is accepted normally (IDLE branch), giving zero bubble.
- Output timing:
  - o_cw_*, o_sym_idx, o_err and o_blk_cnt are registered, one cycle after the accepting input edge.
  - o_cw_* are 0 in cycles with no accepted symbol; o_sym_idx holds its last value.
  - o_busy is high while the FSM is in RUN.
- Delay pipe: the tuple {valid, start, last, abort} is shifted through pLatency flops, so o_dly_x(t) = o_cw_x(t - pLatency).
- o_cw_abort coincides with the restarted symbol's o_cw_start. Both propagate together, so downstream discards the old codeword before taking the new one.
- pCodeLen = 2**pCntWidth must work: the last-symbol compare runs before the increment, so the counter never overflows.

Test Plan:
- Reset, then 15 contiguous valid symbols with i_start on the first -> o_sym_idx runs 0..14 with o_cw_start on idx 0 and o_cw_last on idx 14. o_dly_* repeat the pattern 4 cycles later. o_blk_cnt = 1, o_busy low after the last symbol.
- Two codewords back-to-back, the second i_start in the cycle after the first last symbol -> no idle cycle on o_cw_valid, o_blk_cnt = 2, o_err never asserts.
- One codeword with i_valid low for 3 cycles after idx 5 -> o_sym_idx holds at 5, then continues 6..14; only 15 o_cw_valid pulses; o_busy held high through the gap.
- i_start after 7 symbols -> o_cw_abort, o_err and o_cw_start pulse together with idx 0. A following 14 symbols end with the last tag. o_blk_cnt = 1, and o_dly_abort appears 4 cycles after o_cw_abort.
- i_valid without i_start while IDLE -> o_err pulses once, o_cw_valid stays 0, o_busy stays 0, o_blk_cnt unchanged.
- rst_x pulsed low at idx 9, then a fresh codeword -> all outputs and the delay pipe read 0 during reset; the new codeword indexes 0..14 and o_blk_cnt ends at 1.
